// File: rtl/i2c_poll_scheduler.sv
// i2c_poll_scheduler: periodically reads REG_ADDR of sensor DEV_ADDR through the I2C master and publishes the beat value.
// Latency: poll tick -> m_start 2 cycles (master idle); m_done -> bpm_valid 2 cycles.
// Backpressure: m_start is held off while m_busy=1; ticks arriving while a poll is pending are dropped.
// Optional: define HR_AVG4_EN to publish the mean of the last 4 good samples instead of the raw byte.
module i2c_poll_scheduler #(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter int unsigned TIMEOUT     = 500,
  parameter int unsigned MAX_RETRY   = 2,
  parameter logic [7:0]  DEV_ADDR    = 8'h0A,
  parameter logic [7:0]  REG_ADDR    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        m_start,
  output logic [7:0]  m_add,
  output logic [7:0]  m_reg,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic        m_ack_err,
  input  logic [7:0]  m_dout,
  output logic [7:0]  bpm,
  output logic        bpm_valid,
  output logic        err,
  output logic [15:0] sample_cnt,
  output logic [2:0]  state_dbg
);

  localparam int unsigned TICK_W = $clog2(POLL_PERIOD);
  localparam int unsigned TO_W   = $clog2(TIMEOUT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(POLL_PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [2:0]        MAX_R     = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CHECK     = 3'd4,
    S_PUBLISH   = 3'd5,
    S_FAIL      = 3'd6,
    S_BACKOFF   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q;
  logic              tick_pend_q;
  logic [TO_W-1:0]   to_q;
  logic [2:0]        retry_q;
  logic [7:0]        cap_q;
  logic              ack_q;
  logic [7:0]        bpm_q;
  logic              bpm_valid_q;
  logic              err_q;
  logic [15:0]       cnt_q;
  logic              pub;
  logic [7:0]        pub_val;

  // A good read is committed on the CHECK->PUBLISH edge so bpm and its strobe appear together.
  assign pub = (state_q == S_CHECK) && !ack_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping enable never aborts a transaction already started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (!enable)                     state_d = S_IDLE;
        else if (tick_pend_q && !m_busy) state_d = S_ISSUE;
      end
      // Hold here if the master became busy since the decision, so m_start never overlaps m_busy.
      S_ISSUE:     if (!m_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (m_done)              state_d = S_CHECK;
        else if (to_q == TO_LAST) state_d = S_FAIL;
      end
      S_CHECK:     state_d = ack_q ? S_FAIL : S_PUBLISH;
      S_PUBLISH:   state_d = enable ? S_WAIT_TICK : S_IDLE;
      S_FAIL: begin
        if (retry_q < MAX_R) state_d = S_BACKOFF;
        else                 state_d = enable ? S_WAIT_TICK : S_IDLE;
      end
      S_BACKOFF: begin
        if (!enable)     state_d = S_IDLE;
        else if (!m_busy) state_d = S_ISSUE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    m_start    = (state_q == S_ISSUE) && !m_busy;
    m_add      = DEV_ADDR;
    m_reg      = REG_ADDR;
    state_dbg  = state_q;
    bpm        = bpm_q;
    bpm_valid  = bpm_valid_q;
    err        = err_q;
    sample_cnt = cnt_q;
  end

  // Free-running poll period counter, only while enabled.
  always_ff @(posedge clk) begin
    if (reset || !enable)      tick_q <= '0;
    else if (tick_q == TICK_LAST) tick_q <= '0;
    else                       tick_q <= tick_q + TICK_W'(1);
  end

  // Single pending-poll flag; a fresh tick wins over consumption in the same cycle, and
  // disabling discards any stale request so re-enable starts from a clean period.
  always_ff @(posedge clk) begin
    if (reset || !enable)                                tick_pend_q <= 1'b0;
    else if (tick_q == TICK_LAST)                        tick_pend_q <= 1'b1;
    else if (state_q == S_WAIT_TICK && state_d == S_ISSUE) tick_pend_q <= 1'b0;
  end

  // Transaction timeout counter, restarted for every attempt.
  always_ff @(posedge clk) begin
    if (reset)                       to_q <= '0;
    else if (state_q == S_ISSUE)     to_q <= '0;
    else if (state_q == S_WAIT_DONE) to_q <= to_q + TO_W'(1);
  end

  // Capture the master result on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= 8'd0;
      ack_q <= 1'b0;
    end else if (state_q == S_WAIT_DONE && m_done) begin
      cap_q <= m_dout;
      ack_q <= m_ack_err;
    end
  end

  // Retry bookkeeping within one poll.
  always_ff @(posedge clk) begin
    if (reset) begin
      retry_q <= 3'd0;
    end else begin
      case (state_q)
        S_PUBLISH: retry_q <= 3'd0;
        S_FAIL:    retry_q <= (retry_q < MAX_R) ? retry_q + 3'd1 : 3'd0;
        S_BACKOFF: if (!enable) retry_q <= 3'd0;
        default:   retry_q <= retry_q;
      endcase
    end
  end

  // Published value, strobe, sample counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      bpm_q       <= 8'd0;
      bpm_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      bpm_valid_q <= pub;
      if (pub) begin
        bpm_q <= pub_val;
        cnt_q <= cnt_q + 16'd1;
        err_q <= 1'b0;
      end else if (state_q == S_FAIL && !(retry_q < MAX_R)) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef HR_AVG4_EN
  // Three previous good samples (zero until filled) and how many are valid.
  logic [7:0]  h0_q, h1_q, h2_q;
  logic [1:0]  nprev_q;
  logic [9:0]  sum;
  logic [19:0] third;

  // Running mean; divide by 3 as multiply by 683/2048, exact floor for sums up to 765.
  always_comb begin
    sum     = 10'(cap_q) + 10'(h0_q) + 10'(h1_q) + 10'(h2_q);
    third   = 20'(sum) * 20'd683;
    pub_val = 8'd0;
    case (nprev_q)
      2'd0:    pub_val = sum[7:0];
      2'd1:    pub_val = sum[8:1];
      2'd2:    pub_val = third[18:11];
      default: pub_val = sum[9:2];
    endcase
  end

  // Shift history on every published sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      h0_q    <= 8'd0;
      h1_q    <= 8'd0;
      h2_q    <= 8'd0;
      nprev_q <= 2'd0;
    end else if (pub) begin
      h0_q <= cap_q;
      h1_q <= h0_q;
      h2_q <= h1_q;
      if (nprev_q != 2'd3) nprev_q <= nprev_q + 2'd1;
    end
  end
`else
  // Raw byte straight from the sensor.
  always_comb begin
    pub_val = cap_q;
  end
`endif

endmodule
